// File: rtl/fb_writer_if.sv
// Pixel-write, scan-out read and clear-control bundle for the framebuffer writer.
interface fb_writer_if;
    logic        tile_mode;
    logic [4:0]  tile_x;
    logic [3:0]  tile_y;
    logic        write_en;
    logic [2:0]  colour;
    logic [16:0] offset;
    logic        rd_req;
    logic [8:0]  rd_x;
    logic [7:0]  rd_y;
    logic        rd_valid;
    logic [2:0]  rd_colour;
    logic        clear_go;
    logic [2:0]  clear_colour;
    logic        clear_done;
    logic        fifo_empty;
    logic        overflow;
    logic [16:0] pix_count;

    modport master (
        output tile_mode, tile_x, tile_y, write_en, colour, offset,
        output rd_req, rd_x, rd_y, clear_go, clear_colour,
        input  rd_valid, rd_colour, clear_done, fifo_empty, overflow, pix_count
    );

    modport slave (
        input  tile_mode, tile_x, tile_y, write_en, colour, offset,
        input  rd_req, rd_x, rd_y, clear_go, clear_colour,
        output rd_valid, rd_colour, clear_done, fifo_empty, overflow, pix_count
    );
endinterface

// File: rtl/fb_writer.sv
// Framebuffer writer: decodes screen/tile pixel beats to linear addresses,
// queues them in a small FIFO and commits them to a single-port 3-bit RAM
// shared with a scan-out read port (highest priority) and a bulk clear engine.
module fb_writer #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int FIFO_DEPTH = 4     // power of two, at least 2
) (
    input  logic       clk,
    input  logic       reset_n,      // active-high asynchronous reset
    fb_writer_if.slave bus
);
    localparam int          NPIX      = WIDTH * HEIGHT;
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [16:0] LAST_ADDR = 17'(NPIX - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [16:0] clr_addr_q, clr_addr_d;
    logic [2:0]  clr_col_q, clr_col_d;
    logic        clr_we;

    logic [8:0]  wx;
    logic [7:0]  wy;
    logic        w_inrange;
    logic [16:0] w_addr;
    logic        r_inrange;
    logic [16:0] r_addr;

    logic [19:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [19:0]   head;
    logic          full, push, pop, drop;

    logic        fifo_empty_q, overflow_q;
    logic [16:0] pix_count_q;

    logic [2:0]  ram [NPIX];
    logic [2:0]  ram_rd_q;
    logic        rd_vld1_q, rd_oor1_q;
    logic        rd_valid_q;
    logic [2:0]  rd_colour_q;

    // Beat address decode; tile coordinates are a plain bit concatenation (origin*16 + local).
    always_comb begin
        if (bus.tile_mode) begin
            wx = {bus.tile_x, bus.offset[3:0]};
            wy = {bus.tile_y, bus.offset[12:9]};
        end else begin
            wx = bus.offset[8:0];
            wy = bus.offset[16:9];
        end
        w_inrange = (32'(wx) < WIDTH) && (32'(wy) < HEIGHT);
        w_addr    = 17'(32'(wy) * WIDTH + 32'(wx));
    end

    // Scan-out read address decode.
    always_comb begin
        r_inrange = (32'(bus.rd_x) < WIDTH) && (32'(bus.rd_y) < HEIGHT);
        r_addr    = 17'(32'(bus.rd_y) * WIDTH + 32'(bus.rd_x));
    end

    // Only the idle state drains, and only when the read port leaves the RAM free.
    assign full = cnt_q[AW];
    assign head = fifo_mem[rd_ptr_q];
    assign pop  = (state_q == S_IDLE) && !bus.rd_req && (cnt_q != '0);
    assign push = bus.write_en && w_inrange && (!full || pop);
    assign drop = bus.write_en && w_inrange && full && !pop;

    // FIFO pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO storage holds {address, colour}; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {w_addr, bus.colour};
    end

    // Clear-engine FSM: a read request stalls the sweep for that cycle.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_col_d  = clr_col_q;
        clr_we     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.clear_go) begin
                    state_d    = S_CLEAR;
                    clr_addr_d = '0;
                    clr_col_d  = bus.clear_colour;
                end
            end
            S_CLEAR: begin
                if (!bus.rd_req) begin
                    clr_we = 1'b1;
                    if (clr_addr_q == LAST_ADDR) state_d = S_DONE;
                    else                         clr_addr_d = clr_addr_q + 17'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Single RAM port: read, then clear write, then FIFO pop.
    always_ff @(posedge clk) begin
        if (bus.rd_req) begin
            if (r_inrange) ram_rd_q <= ram[r_addr];
        end else if (clr_we) begin
            ram[clr_addr_q] <= clr_col_q;
        end else if (pop) begin
            ram[head[19:3]] <= head[2:0];
        end
    end

    // Control state, FIFO bookkeeping, status and two-stage read pipeline.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q      <= S_IDLE;
            clr_addr_q   <= '0;
            clr_col_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            fifo_empty_q <= 1'b1;
            overflow_q   <= 1'b0;
            pix_count_q  <= '0;
            rd_vld1_q    <= 1'b0;
            rd_oor1_q    <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_colour_q  <= '0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            clr_col_q    <= clr_col_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            fifo_empty_q <= (cnt_d == '0);
            if (drop) overflow_q <= 1'b1;
            if (pop)  pix_count_q <= pix_count_q + 17'd1;
            rd_vld1_q    <= bus.rd_req;
            rd_oor1_q    <= !r_inrange;
            rd_valid_q   <= rd_vld1_q;
            rd_colour_q  <= (rd_vld1_q && !rd_oor1_q) ? ram_rd_q : 3'd0;
        end
    end

    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_colour  = rd_colour_q;
    assign bus.clear_done = (state_q == S_DONE);
    assign bus.fifo_empty = fifo_empty_q;
    assign bus.overflow   = overflow_q;
    assign bus.pix_count  = pix_count_q;
endmodule

// File: tb/tb_fb_writer.sv
// Bench for fb_writer: reset values, a vector table of decode/range cases,
// overflow, full clear, random traffic against a shadow framebuffer, and
// reset during a clear.
module tb_fb_writer;
    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    int   cyc     = 0;
    int   n_chk   = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    // Cycle counter used to time read responses and the clear pulse.
    always @(posedge clk) cyc <= cyc + 1;

    fb_writer_if bus ();

    fb_writer #(.WIDTH(320), .HEIGHT(240), .FIFO_DEPTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int         cyc;
        logic [2:0] col;
    } rexp_t;

    typedef struct {
        logic        tm;
        logic [4:0]  tx;
        logic [3:0]  ty;
        logic [16:0] off;
        logic [2:0]  col;
        int          acc;
        int          rx;
        int          ry;
        logic [2:0]  rexp;
    } vec_t;

    rexp_t      rq[$];
    rexp_t      mon_r;
    logic [2:0] shadow [76800];
    int         pc_exp = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.write_en = 1'b0;
        bus.rd_req   = 1'b0;
        bus.clear_go = 1'b0;
    endtask

    function automatic logic [16:0] scr_off(input int x, input int y);
        logic [7:0] yy;
        logic [8:0] xx;
        yy = 8'(y);
        xx = 9'(x);
        return {yy, xx};
    endfunction

    function automatic logic [2:0] model_rd(input int x, input int y);
        if (x < 320 && y < 240) return shadow[y * 320 + x];
        return 3'd0;
    endfunction

    task automatic beat(input logic tm, input logic [4:0] tx, input logic [3:0] ty,
                        input logic [16:0] off, input logic [2:0] col);
        bus.tile_mode = tm;
        bus.tile_x    = tx;
        bus.tile_y    = ty;
        bus.offset    = off;
        bus.colour    = col;
        bus.write_en  = 1'b1;
    endtask

    task automatic issue_read(input int x, input int y, input logic [2:0] e);
        rexp_t r;
        bus.rd_req = 1'b1;
        bus.rd_x   = 9'(x);
        bus.rd_y   = 8'(y);
        r.cyc = cyc;
        r.col = e;
        rq.push_back(r);
    endtask

    // Read monitor: every issued read must answer exactly two cycles later.
    always @(negedge clk) begin
        if (rq.size() != 0 && cyc == rq[0].cyc + 2) begin
            mon_r = rq.pop_front();
            chk("rd_valid", int'(bus.rd_valid), 1);
            if (bus.rd_valid) chk("rd_colour", int'(bus.rd_colour), int'(mon_r.col));
        end else if (bus.rd_valid) begin
            chk("rd_valid_spurious", int'(bus.rd_valid), 0);
        end
    end

    // Hard stop should anything wedge.
    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[9];
        int          pc0, go_cyc, seen, x, y, rx, ry, lx, ly;
        logic        tm;
        logic [4:0]  tx;
        logic [3:0]  ty;
        logic [16:0] off;
        logic [2:0]  col;

        vt[0] = '{1'b0, 5'd0,  4'd0,  {8'd10, 9'd5},                  3'd5, 1, 5,   10,  3'd5};
        vt[1] = '{1'b1, 5'd3,  4'd2,  {4'd0, 4'd7, 5'd0, 4'd9},       3'd6, 1, 57,  39,  3'd6};
        vt[2] = '{1'b0, 5'd0,  4'd0,  {8'd0, 9'd320},                 3'd7, 0, 320, 0,   3'd0};
        vt[3] = '{1'b0, 5'd0,  4'd0,  {8'd240, 9'd0},                 3'd7, 0, 0,   240, 3'd0};
        vt[4] = '{1'b0, 5'd0,  4'd0,  {8'd239, 9'd319},               3'd3, 1, 319, 239, 3'd3};
        vt[5] = '{1'b1, 5'd19, 4'd14, {4'hF, 4'd15, 5'h1F, 4'd15},    3'd1, 1, 319, 239, 3'd1};
        vt[6] = '{1'b1, 5'd20, 4'd0,  17'd0,                          3'd4, 0, 511, 255, 3'd0};
        vt[7] = '{1'b1, 5'd0,  4'd15, 17'd0,                          3'd4, 0, 0,   255, 3'd0};
        vt[8] = '{1'b0, 5'd0,  4'd0,  {8'd0, 9'd0},                   3'd7, 1, 0,   0,   3'd7};

        quiet();
        bus.tile_mode = 1'b0; bus.tile_x = '0; bus.tile_y = '0;
        bus.offset = '0; bus.colour = '0; bus.rd_x = '0; bus.rd_y = '0;
        bus.clear_colour = '0;
        repeat (3) tick();
        chk("rst_rd_valid",   int'(bus.rd_valid), 0);
        chk("rst_rd_colour",  int'(bus.rd_colour), 0);
        chk("rst_clear_done", int'(bus.clear_done), 0);
        chk("rst_fifo_empty", int'(bus.fifo_empty), 1);
        chk("rst_overflow",   int'(bus.overflow), 0);
        chk("rst_pix_count",  int'(bus.pix_count), 0);
        reset_n = 1'b0;
        tick();

        // Decode / range vectors: write, let it drain, read it back.
        for (int i = 0; i < 9; i++) begin
            beat(vt[i].tm, vt[i].tx, vt[i].ty, vt[i].off, vt[i].col);
            tick(); quiet(); tick(); tick();
            issue_read(vt[i].rx, vt[i].ry, vt[i].rexp);
            tick(); quiet(); tick(); tick();
            pc_exp += vt[i].acc;
            chk("vec_pix_count",  int'(bus.pix_count), pc_exp);
            chk("vec_fifo_empty", int'(bus.fifo_empty), 1);
            chk("vec_overflow",   int'(bus.overflow), 0);
        end

        // Overflow: reads hog the port so nothing drains; fifth beat is dropped.
        pc0 = pc_exp;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) chk("ovf_before_5th", int'(bus.overflow), 0);
            beat(1'b0, 5'd0, 4'd0, scr_off(100 + i, 50), 3'(i + 1));
            issue_read(400, 10, 3'd0);
            tick();
        end
        bus.write_en = 1'b0;
        chk("ovf_set",        int'(bus.overflow), 1);
        chk("ovf_fifo_full",  int'(bus.fifo_empty), 0);
        chk("ovf_no_commit",  int'(bus.pix_count), pc0);
        quiet();
        repeat (6) tick();
        pc_exp = pc0 + 4;
        chk("ovf_drain_count", int'(bus.pix_count), pc_exp);
        chk("ovf_drain_empty", int'(bus.fifo_empty), 1);
        for (int i = 0; i < 4; i++) begin
            issue_read(100 + i, 50, 3'(i + 1));
            tick();
        end
        quiet(); repeat (3) tick();

        // Full clear with a beat queued part-way through.
        bus.clear_go = 1'b1; bus.clear_colour = 3'b010;
        go_cyc = cyc;
        tick(); quiet();
        repeat (10) tick();
        beat(1'b0, 5'd0, 4'd0, scr_off(7, 7), 3'd6);
        tick(); quiet(); tick();
        chk("clr_beat_held",  int'(bus.fifo_empty), 0);
        chk("clr_pc_held",    int'(bus.pix_count), pc_exp);
        while (!bus.clear_done && cyc < go_cyc + 80000) tick();
        chk("clr_done_cycle", cyc, go_cyc + 76801);
        chk("clr_pc_at_done", int'(bus.pix_count), pc_exp);
        tick();
        chk("clr_done_pulse", int'(bus.clear_done), 0);
        tick();
        pc_exp++;
        chk("clr_beat_commit", int'(bus.pix_count), pc_exp);
        chk("clr_fifo_empty",  int'(bus.fifo_empty), 1);
        for (int a = 0; a < 76800; a++) shadow[a] = 3'd2;
        shadow[7 * 320 + 7] = 3'd6;
        issue_read(0, 0, model_rd(0, 0));       tick();
        issue_read(319, 239, model_rd(319, 239)); tick();
        issue_read(7, 7, model_rd(7, 7));       tick();
        issue_read(100, 50, model_rd(100, 50)); tick();
        quiet(); repeat (3) tick();

        // Random beats at copy-engine cadence with random reads.
        lx = 0; ly = 0;
        for (int it = 0; it < 150; it++) begin
            tm = 1'($urandom_range(0, 1));
            if (!tm) begin
                x = $urandom_range(0, 335); y = $urandom_range(0, 245);
                off = scr_off(x, y); tx = '0; ty = '0;
            end else begin
                tx = 5'($urandom_range(0, 21)); ty = 4'($urandom_range(0, 15));
                off = 17'($urandom);
                x = int'(tx) * 16 + int'(off) % 16;
                y = int'(ty) * 16 + (int'(off) / 512) % 16;
            end
            col = 3'($urandom);
            beat(tm, tx, ty, off, col);
            if ($urandom_range(0, 1) == 1) begin
                rx = $urandom_range(0, 330); ry = $urandom_range(0, 245);
                issue_read(rx, ry, model_rd(rx, ry));
            end
            tick(); quiet();
            if (x < 320 && y < 240) begin
                shadow[y * 320 + x] = col;
                pc_exp++;
                lx = x; ly = y;
            end
            tick();
            for (int j = 0; j < 3; j++) begin
                if ($urandom_range(0, 3) != 0) begin
                    if ($urandom_range(0, 1) == 1) begin rx = lx; ry = ly; end
                    else begin rx = $urandom_range(0, 330); ry = $urandom_range(0, 245); end
                    issue_read(rx, ry, model_rd(rx, ry));
                end
                tick(); quiet();
            end
            chk("rnd_pix_count", int'(bus.pix_count), pc_exp & 17'h1FFFF);
        end
        repeat (3) tick();

        // Reset roughly 100 cycles into a clear, with a beat still queued.
        bus.clear_go = 1'b1; bus.clear_colour = 3'd5;
        tick(); quiet();
        repeat (50) tick();
        beat(1'b0, 5'd0, 4'd0, scr_off(3, 3), 3'd1);
        tick(); quiet();
        repeat (48) tick();
        chk("abort_pre_fifo",  int'(bus.fifo_empty), 0);
        chk("abort_pre_ovf",   int'(bus.overflow), 1);
        reset_n = 1'b1;
        #1;
        chk("abort_async_pc",  int'(bus.pix_count), 0);
        tick();
        reset_n = 1'b0;
        tick();
        chk("abort_rd_valid",   int'(bus.rd_valid), 0);
        chk("abort_rd_colour",  int'(bus.rd_colour), 0);
        chk("abort_clear_done", int'(bus.clear_done), 0);
        chk("abort_fifo_empty", int'(bus.fifo_empty), 1);
        chk("abort_overflow",   int'(bus.overflow), 0);
        chk("abort_pix_count",  int'(bus.pix_count), 0);
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bus.clear_done) seen++;
        end
        chk("abort_no_done",  seen, 0);
        chk("abort_pc_still", int'(bus.pix_count), 0);
        beat(1'b0, 5'd0, 4'd0, scr_off(20, 30), 3'd5);
        tick(); quiet(); tick();
        issue_read(20, 30, 3'd5);
        tick(); quiet(); repeat (3) tick();
        chk("post_abort_pc",  int'(bus.pix_count), 1);

        repeat (3) tick();
        chk("reads_outstanding", rq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fb_writer.md
# fb_writer

Receiving end of the pixel-write stream produced by the screen/tile copy engine. Accepts `write_en`/`colour`/`offset` beats in either full-screen or 16x16-tile offset format, translates them to a linear 320x240 framebuffer address, buffers them in a small FIFO, and commits them to an internal single-port 3-bit framebuffer RAM. The RAM is shared with a scan-out read port (priority) and a bulk clear engine.

## Interface
- `WIDTH`, 320, framebuffer width in pixels
- `HEIGHT`, 240, framebuffer height in pixels
- `FIFO_DEPTH`, 4, write FIFO entries (power of two)
- `clk`  in  1  sole clock, rising edge
- `reset_n`  in  1  reset; asynchronous, active-high (asserted = 1, despite the name)
- `tile_mode`  in  1  1: offset is tile format; 0: offset is {y[7:0], x[8:0]}
- `tile_x`  in  5  tile column origin (0..19), tile mode only
- `tile_y`  in  4  tile row origin (0..14), tile mode only
- `write_en`  in  1  one pixel-write beat this cycle
- `colour`  in  3  pixel colour
- `offset`  in  17  pixel offset
- `rd_req`  in  1  scan-out read request
- `rd_x`  in  9  read column
- `rd_y`  in  8  read row
- `rd_valid`  out  1  read data valid (one-cycle pulse)
- `rd_colour`  out  3  read data
- `clear_go`  in  1  start bulk clear (level, sampled in S_IDLE)
- `clear_colour`  in  3  fill colour, latched at clear start
- `clear_done`  out  1  one-cycle pulse at clear completion
- `fifo_empty`  out  1  write FIFO empty
- `overflow`  out  1  sticky: a beat was dropped on a full FIFO
- `pix_count`  out  17  committed pixel writes, wraps at 2^17

## Operation
- Address decode, applied when a beat is accepted:
  - Screen mode: x = offset[8:0], y = offset[16:9].
  - Tile mode: x = tile_x*16 + offset[3:0], y = tile_y*16 + offset[12:9]. Offset bits 8:4 and 16:13 are ignored.
  - Linear address = y*WIDTH + x, 17 bits, unsigned.
- Range check: a beat with x >= WIDTH or y >= HEIGHT is silently discarded. It is not enqueued and does not count.
- FIFO entry = {address[16:0], colour[2:0]}.
- Enqueue: accepted when `write_en`=1, the beat is in range, and the FIFO is not full, or the FIFO is full and a pop occurs in the same cycle.
- Overflow: a beat arriving on a full FIFO with no same-cycle pop is dropped and sets `overflow`. `overflow` clears only on reset.
- RAM port arbitration, one access per cycle, priority order:
  - `rd_req`
  - clear-engine write (S_CLEAR)
  - FIFO pop (S_IDLE only)
- A FIFO pop writes the RAM and increments `pix_count`. Clear writes do not count.
- Read: linear address rd_y*WIDTH + rd_x. An out-of-range read returns colour 0, still with `rd_valid`.
- FSM states:
  - S_IDLE: FIFO drains. `clear_go`=1 goes to S_CLEAR, latching `clear_colour` and zeroing the clear address.
  - S_CLEAR: each cycle without `rd_req`, write `clear_colour` at the clear address and increment it. After writing address WIDTH*HEIGHT-1, go to S_DONE. Incoming beats still enqueue but do not drain.
  - S_DONE: `clear_done`=1 for one cycle, then go to S_IDLE. FIFO drain resumes the following cycle.
- Reset mid-operation: FIFO is emptied, the FSM goes to S_IDLE, and any clear is abandoned. RAM contents are undefined after a clear abort; they are not re-initialised.

## Timing
- Reset values:
  - `rd_valid`=0, `rd_colour`=0, `clear_done`=0
  - `fifo_empty`=1, `overflow`=0, `pix_count`=0
  - FSM in S_IDLE
- Write latency: a beat in cycle k enters the FIFO at edge k. With an empty FIFO and no competing access in cycle k+1, the RAM write happens at the end of cycle k+1.
- Read latency: `rd_req` in cycle k produces `rd_valid`=1 with `rd_colour` in cycle k+2. Throughput is one read per cycle.
- A read issued in the cycle after a RAM write to the same address returns the new data.
- The FIFO drains one entry per free cycle. Under the copy engine's cadence (at most one beat per 5 cycles), any read pattern leaving 1 free cycle in 5 never overflows.
- Full clear with no reads takes WIDTH*HEIGHT = 76800 cycles in S_CLEAR plus 1 cycle in S_DONE.
- `fifo_empty` and `pix_count` are registered and update the cycle after the edge that changes them.

## Test plan
- Screen-mode write: offset={8'd10, 9'd5}, colour=3'b101, no reads. Then `rd_req` at (5,10) yields `rd_valid` 2 cycles later with colour 5, and `pix_count`=1.
- Tile mode: tile_x=3, tile_y=2, offset={4'd0, 4'd7, 5'd0, 4'd9} writes pixel (57,39). A read there returns the written colour.
- Range discard: screen-mode offset with x=320 gives no FIFO entry, unchanged `pix_count`, and `overflow`=0.
- Overflow: `rd_req` held high continuously, 5 back-to-back write beats. The first 4 are accepted, the 5th is dropped, and `overflow`=1. After releasing `rd_req`, 4 pops occur and `pix_count`=4.
- Clear: `clear_go` with `clear_colour`=3'b010 and no reads. `clear_done` pulses 76801 cycles later. Reads of (0,0) and (319,239) return 2. A beat queued during the clear commits after `clear_done`.
- Reset mid-clear: assert `reset_n` 100 cycles into S_CLEAR. All outputs return to reset values. A subsequent write and read behave normally.
